// File: rtl/net_link_tx_dispatch_pkg.sv
// Shared types and constants for the network-layer to link-TX dispatcher.
// Contents: connection-id and data widths, per-port word layout, the
// network-layer TX payload, the FIFO entry layout, the dispatcher FSM
// states, status-word field positions and a saturating counter helper.
package net_link_tx_dispatch_pkg;

  localparam int unsigned CONN_ID_WIDTH     = 2;
  localparam int unsigned NUM_CONN          = 1 << CONN_ID_WIDTH;
  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam int unsigned CNT_WIDTH         = 8;
  localparam int unsigned STATUS_WIDTH      = 2 * CNT_WIDTH;
  localparam int unsigned STATUS_BAD_CONN_LSB = CNT_WIDTH;
  localparam int unsigned STATUS_FRAMING_LSB  = 0;

  typedef logic [CONN_ID_WIDTH-1:0] conn_id_t;
  typedef logic [CNT_WIDTH-1:0]     err_cnt_t;

  typedef struct packed {
    logic                  valid;
    logic                  first;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } packet_word_t;

  typedef struct packed {
    packet_word_t packet_word;
    logic         controller_packet;
    conn_id_t     connection_id;
  } net_layer_packet_tx_t;

  typedef struct packed {
    logic                  first;
    logic                  last;
    logic                  ctrl;
    conn_id_t              conn_id;
    logic [DATA_WIDTH-1:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } dispatch_state_t;

  // Increment that sticks at all-ones.
  function automatic err_cnt_t sat_inc(input err_cnt_t v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/net_link_tx_dispatch_skid_fifo.sv
// net_tx_skid_fifo: small synchronous FIFO absorbing the upstream
// ready-to-valid slip.
// Ports: clk, rst_n; wr_en/wr_data write side (writes while full are
// dropped and flagged on overflow_c); rd_en pops the head; head_c /
// head_valid_c present the head entry; occupancy is the entry count;
// wr_ready is the registered early ready (occupancy <= DEPTH-2), low in reset.
module net_tx_skid_fifo
  import net_link_tx_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  fifo_entry_t              wr_data,
  input  logic                     rd_en,
  output fifo_entry_t              head_c,
  output logic                     head_valid_c,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     wr_ready,
  output logic                     overflow_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  fifo_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ_d;
  logic               full;
  logic               wr_ok;
  logic               rd_ok;

  assign full         = (occupancy == OCC_W'(DEPTH));
  assign head_valid_c = (occupancy != '0);
  assign head_c       = mem[rd_ptr];
  assign wr_ok        = wr_en && !full;
  assign rd_ok        = rd_en && head_valid_c;
  assign overflow_c   = wr_en && full;

  // Next occupancy; simultaneous write and pop leaves it unchanged.
  always_comb begin
    occ_d = occupancy;
    if (wr_ok && !rd_ok) occ_d = occupancy + OCC_W'(1);
    if (rd_ok && !wr_ok) occ_d = occupancy - OCC_W'(1);
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and early ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      wr_ready  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy <= occ_d;
      wr_ready  <= (occ_d <= OCC_W'(DEPTH - 2));
    end
  end

endmodule

// File: rtl/net_link_tx_dispatch.sv
// net_link_tx_dispatch: steers whole packets from the network-layer TX stage
// to the link-TX port selected by the packet's first-word connection_id.
// Ports: clk, rst_n; layer_tx input word with layer_tx_ready early ready;
// num_connections_minus_one highest legal id; link_tx / link_tx_ctrl per-port
// output slots with link_tx_ready backpressure; dispatch_error_status
// {bad_conn_cnt, framing_err_cnt}; fifo_overflow sticky overflow flag.
module net_link_tx_dispatch
  import net_link_tx_dispatch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  net_layer_packet_tx_t      layer_tx,
  output logic                      layer_tx_ready,
  input  logic [CONN_ID_WIDTH-1:0]  num_connections_minus_one,
  output packet_word_t              link_tx [NUM_CONN],
  output logic [NUM_CONN-1:0]       link_tx_ctrl,
  input  logic [NUM_CONN-1:0]       link_tx_ready,
  output logic [STATUS_WIDTH-1:0]   dispatch_error_status,
  output logic                      fifo_overflow
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

  fifo_entry_t         wr_entry;
  fifo_entry_t         head;
  logic                head_valid;
  logic [OCC_W-1:0]    occupancy;
  logic                overflow_c;

  dispatch_state_t     state_q, state_d;
  conn_id_t            sel_q, sel_d;
  logic                pop;
  logic [NUM_CONN-1:0] load;
  logic [NUM_CONN-1:0] slot_free;
  logic                bad_inc;
  logic                frm_inc;
  err_cnt_t            bad_cnt_q;
  err_cnt_t            frm_cnt_q;

  assign wr_entry = '{first:   layer_tx.packet_word.first,
                      last:    layer_tx.packet_word.last,
                      ctrl:    layer_tx.controller_packet,
                      conn_id: layer_tx.connection_id,
                      data:    layer_tx.packet_word.data};

  // Upstream has committed the word, so every valid word is written.
  net_tx_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (layer_tx.packet_word.valid),
    .wr_data      (wr_entry),
    .rd_en        (pop),
    .head_c       (head),
    .head_valid_c (head_valid),
    .occupancy    (occupancy),
    .wr_ready     (layer_tx_ready),
    .overflow_c   (overflow_c)
  );

  always_comb assert (occupancy <= OCC_W'(FIFO_DEPTH));

  // A slot can take a word if empty or if its word leaves this cycle.
  always_comb begin
    for (int i = 0; i < NUM_CONN; i++) begin
      slot_free[i] = !link_tx[i].valid || link_tx_ready[i];
    end
  end

  // Dispatcher next-state and control.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pop     = 1'b0;
    load    = '0;
    bad_inc = 1'b0;
    frm_inc = 1'b0;
    if (head_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!head.first) begin
            frm_inc = 1'b1;
            pop     = 1'b1;
          end else if (head.conn_id <= num_connections_minus_one) begin
            sel_d = head.conn_id;
            if (slot_free[head.conn_id]) begin
              pop                = 1'b1;
              load[head.conn_id] = 1'b1;
              if (!head.last) state_d = FWD;
            end
          end else begin
            bad_inc = 1'b1;
            pop     = 1'b1;
            if (!head.last) state_d = DROP;
          end
        end
        FWD: begin
          // A new first word truncates the packet; it is re-run from IDLE.
          if (head.first) begin
            frm_inc = 1'b1;
            state_d = IDLE;
          end else if (slot_free[sel_q]) begin
            pop         = 1'b1;
            load[sel_q] = 1'b1;
            if (head.last) state_d = IDLE;
          end
        end
        DROP: begin
          if (head.first) begin
            frm_inc = 1'b1;
            state_d = IDLE;
          end else begin
            pop = 1'b1;
            if (head.last) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, selection, counters and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      bad_cnt_q     <= '0;
      frm_cnt_q     <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (bad_inc)    bad_cnt_q     <= sat_inc(bad_cnt_q);
      if (frm_inc)    frm_cnt_q     <= sat_inc(frm_cnt_q);
      if (overflow_c) fifo_overflow <= 1'b1;
    end
  end

  // Per-port output slots; data holds while valid and not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CONN; i++) link_tx[i] <= '0;
      link_tx_ctrl <= '0;
    end else begin
      for (int i = 0; i < NUM_CONN; i++) begin
        if (load[i]) begin
          link_tx[i]      <= '{valid: 1'b1, first: head.first,
                               last: head.last, data: head.data};
          link_tx_ctrl[i] <= head.ctrl;
        end else if (link_tx_ready[i]) begin
          link_tx[i].valid <= 1'b0;
        end
      end
    end
  end

  assign dispatch_error_status = {bad_cnt_q, frm_cnt_q};

endmodule

// File: tb/tb_net_link_tx_dispatch.sv
// Testbench for net_link_tx_dispatch: directed packets, expected words
// queued at stimulus time and checked by a decoupled output monitor.
module tb_net_link_tx_dispatch;
  import net_link_tx_dispatch_pkg::*;

  typedef struct {
    int          port;
    logic        first;
    logic        last;
    logic        ctrl;
    logic [31:0] data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  net_layer_packet_tx_t     layer_tx;
  logic                     layer_tx_ready;
  logic [CONN_ID_WIDTH-1:0] ncm1;
  packet_word_t             link_tx [NUM_CONN];
  logic [NUM_CONN-1:0]      link_tx_ctrl;
  logic [NUM_CONN-1:0]      link_tx_ready;
  logic [STATUS_WIDTH-1:0]  status;
  logic                     fifo_overflow;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_rx = 0;
  int   first_rx_cyc = -1;
  exp_t exp_q[$];

  net_link_tx_dispatch dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .layer_tx                  (layer_tx),
    .layer_tx_ready            (layer_tx_ready),
    .num_connections_minus_one (ncm1),
    .link_tx                   (link_tx),
    .link_tx_ctrl              (link_tx_ctrl),
    .link_tx_ready             (link_tx_ready),
    .dispatch_error_status     (status),
    .fifo_overflow             (fifo_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [NUM_CONN-1:0] valids();
    logic [NUM_CONN-1:0] v;
    for (int p = 0; p < NUM_CONN; p++) v[p] = link_tx[p].valid;
    return v;
  endfunction

  // Pops one expected word per accepted output word.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NUM_CONN; p++) begin
        if (rst_n && link_tx[p].valid && link_tx_ready[p]) begin
          if (n_rx == 0) first_rx_cyc = cyc;
          n_rx++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: port %0d data 0x%0h, want no word", p, link_tx[p].data);
          end else begin
            e = exp_q.pop_front();
            check("out_port", 64'(p), 64'(e.port));
            check("out_word", {link_tx[p].first, link_tx[p].last, link_tx_ctrl[p], link_tx[p].data},
                  {e.first, e.last, e.ctrl, e.data});
          end
        end
      end
    end
  endtask

  task automatic put(input logic first, input logic last, input logic ctrl,
                     input logic [1:0] conn, input logic [31:0] data);
    layer_tx.packet_word       = '{valid: 1'b1, first: first, last: last, data: data};
    layer_tx.controller_packet = ctrl;
    layer_tx.connection_id     = conn;
  endtask

  task automatic drive(input logic first, input logic last, input logic ctrl,
                       input logic [1:0] conn, input logic [31:0] data);
    @(posedge clk); #1;
    put(first, last, ctrl, conn, data);
  endtask

  task automatic expect_word(input int port, input logic first, input logic last,
                             input logic ctrl, input logic [31:0] data);
    exp_t e;
    e.port = port; e.first = first; e.last = last; e.ctrl = ctrl; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    @(posedge clk); #1;
    layer_tx = '0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int  i, sent_at_low, t0;
    bit  last_rdy, cur, saw_low;

    rst_n         = 1'b0;
    layer_tx      = '0;
    link_tx_ready = '1;
    ncm1          = 2'd3;
    fork monitor(); join_none

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready",    64'(layer_tx_ready), 64'd0);
    check("rst_valid",    64'(valids()),       64'd0);
    check("rst_ctrl",     64'(link_tx_ctrl),   64'd0);
    check("rst_status",   64'(status),         64'd0);
    check("rst_overflow", 64'(fifo_overflow),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(layer_tx_ready), 64'd1);

    // 1) 3-word packet to conn 2, latency 2.
    expect_word(2, 1'b1, 1'b0, 1'b0, 32'h1111_0001);
    expect_word(2, 1'b0, 1'b0, 1'b0, 32'h1111_0002);
    expect_word(2, 1'b0, 1'b1, 1'b0, 32'h1111_0003);
    drive(1'b1, 1'b0, 1'b0, 2'd2, 32'h1111_0001);
    t0 = cyc;
    drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h1111_0002);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h1111_0003);
    drain("t1_drain", 50);
    check("t1_latency", 64'(first_rx_cyc), 64'(t0 + 2));
    check("t1_rx_count", 64'(n_rx), 64'd3);
    check("t1_status", 64'(status), 64'd0);

    // 2) 6-word packet to conn 1 with port 1 stalled; upstream honours ready one cycle late.
    link_tx_ready[1] = 1'b0;
    i = 0; last_rdy = 1'b1; saw_low = 1'b0; sent_at_low = -1;
    for (int k = 0; k < 80 && i < 6; k++) begin
      @(posedge clk); #1;
      if (k == 12) link_tx_ready[1] = 1'b1;
      cur = layer_tx_ready;
      if (!cur && !saw_low) begin
        saw_low = 1'b1;
        sent_at_low = i;
      end
      if (last_rdy) begin
        expect_word(1, i == 0, i == 5, 1'b1, 32'h2000_0000 + 32'(i));
        put(i == 0, i == 5, 1'b1, 2'd1, 32'h2000_0000 + 32'(i));
        i++;
      end else begin
        layer_tx = '0;
      end
      last_rdy = cur;
    end
    drain("t2_drain", 50);
    check("t2_all_sent", 64'(i), 64'd6);
    check("t2_ready_fell", 64'(saw_low), 64'd1);
    check("t2_words_before_low", 64'(sent_at_low), 64'd4);
    check("t2_no_overflow", 64'(fifo_overflow), 64'd0);

    // 3) Out-of-range conn 3 packet dropped, then conn 0 packet delivered.
    ncm1 = 2'd1;
    drive(1'b1, 1'b0, 1'b0, 2'd3, 32'h3333_0001);
    drive(1'b0, 1'b1, 1'b0, 2'd3, 32'h3333_0002);
    expect_word(0, 1'b1, 1'b1, 1'b1, 32'h3000_00A0);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 32'h3000_00A0);
    drain("t3_drain", 50);
    check("t3_bad_conn_cnt", 64'(status[15:8]), 64'd1);
    check("t3_framing_cnt",  64'(status[7:0]),  64'd0);
    ncm1 = 2'd3;

    // 4) Conn 1 packet cut by a new conn 0 packet.
    expect_word(1, 1'b1, 1'b0, 1'b0, 32'h4100_0001);
    expect_word(1, 1'b0, 1'b0, 1'b0, 32'h4100_0002);
    expect_word(0, 1'b1, 1'b0, 1'b0, 32'h4000_0001);
    expect_word(0, 1'b0, 1'b1, 1'b0, 32'h4000_0002);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 32'h4100_0001);
    drive(1'b0, 1'b0, 1'b0, 2'd1, 32'h4100_0002);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h4000_0001);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h4000_0002);
    drain("t4_drain", 50);
    check("t4_status", 64'(status), 64'h0101);

    // 5) Overfill: slot 3 stalled, 1 slot + 4 FIFO entries hold w0..w4, w5 is dropped.
    link_tx_ready[3] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) expect_word(3, k == 0, 1'b0, 1'b0, 32'h5000_0000 + 32'(k));
      drive(k == 0, 1'b0, 1'b0, 2'd3, 32'h5000_0000 + 32'(k));
    end
    @(posedge clk); #1;
    layer_tx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_overflow_set", 64'(fifo_overflow), 64'd1);
    link_tx_ready[3] = 1'b1;
    drain("t5_drain_a", 50);
    expect_word(3, 1'b0, 1'b1, 1'b0, 32'h5000_0006);
    drive(1'b0, 1'b1, 1'b0, 2'd3, 32'h5000_0006);
    drain("t5_drain_b", 50);
    check("t5_overflow_sticky", 64'(fifo_overflow), 64'd1);
    check("t5_status", 64'(status), 64'h0101);

    // 6) Reset mid-packet while port 2 holds a word.
    link_tx_ready[2] = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'd2, 32'h6000_0001);
    drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h6000_0002);
    @(posedge clk); #1;
    layer_tx = '0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_slot_held", 64'(valids()), 64'b0100);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(valids()), 64'd0);
    check("t6_rst_status", 64'(status), 64'd0);
    check("t6_rst_overflow", 64'(fifo_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    link_tx_ready[2] = 1'b1;
    expect_word(2, 1'b1, 1'b0, 1'b1, 32'h6100_0001);
    expect_word(2, 1'b0, 1'b1, 1'b1, 32'h6100_0002);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 32'h6100_0001);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h6100_0002);
    drain("t6_drain", 50);
    check("t6_status", 64'(status), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
